// File: rtl/recur_seq_engine.sv
// recur_seq_engine: steps a four-register recurrence, either chained (ordered) or all at once (parallel)
// Ports: clk, rst (sync, active-high); start/mode/iters/a_in..d_in are sampled in IDLE;
//        a..d hold the current values; busy is high in RUN; done pulses once per run;
//        step_valid pulses after each update; iter_cnt counts completed iterations.
module recur_seq_engine #(
  parameter int WIDTH = 32,
  parameter int ITER_W = 4,
  parameter int STEP_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ITER_W-1:0] iters,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic [WIDTH-1:0]  c_in,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  c,
  output logic [WIDTH-1:0]  d,
  output logic              busy,
  output logic              done,
  output logic              step_valid,
  output logic [ITER_W-1:0] iter_cnt
);
  localparam int WW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [WW-1:0] LAST = WW'(STEP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt;
  logic [1:0] phase;
  logic mode_q;
  logic [ITER_W-1:0] iters_q;
  logic step, last_step, fin;
  logic [ITER_W-1:0] it_n;
  always_comb begin
    step = state == RUN && wcnt == LAST;
    last_step = step && (mode_q || phase == 2'd3);
    it_n = iter_cnt + 1'b1;
    fin = last_step && it_n == iters_q;
    state_n = state;
    if (state == IDLE) state_n = start ? (iters == '0 ? DONE : RUN) : IDLE;
    else if (state == RUN) state_n = fin ? DONE : RUN;
    else state_n = IDLE;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {a, b, c, d} <= '0;
      iter_cnt <= '0;
      phase <= '0;
      wcnt <= '0;
      mode_q <= 1'b0;
      iters_q <= '0;
      step_valid <= 1'b0;
    end else begin
      state <= state_n;
      step_valid <= step;
      if (state == IDLE && start) begin
        {a, b, c, d} <= {a_in, b_in, c_in, d_in};
        mode_q <= mode;
        iters_q <= iters;
        iter_cnt <= '0;
        phase <= '0;
        wcnt <= '0;
      end else if (state == RUN) begin
        wcnt <= step ? '0 : wcnt + 1'b1;
        if (step) begin
          // Parallel mode enables all four at once; nonblocking reads give the pre-edge values.
          a <= (mode_q || phase == 2'd0) ? b + c : a;
          d <= (mode_q || phase == 2'd1) ? a - WIDTH'(3) : d;
          b <= (mode_q || phase == 2'd2) ? d + WIDTH'(10) : b;
          c <= (mode_q || phase == 2'd3) ? c + 1'b1 : c;
          phase <= mode_q ? 2'd0 : phase + 2'd1;
          if (last_step) iter_cnt <= it_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_recur_seq_engine.sv
// tb_recur_seq_engine: directed table-driven checks of recur_seq_engine plus reset and wrap corner cases
module tb_recur_seq_engine;
  logic clk = 1'b0;
  logic rst, start, mode;
  logic [3:0] iters;
  logic [31:0] a_in, b_in, c_in, d_in, a, b, c, d;
  logic busy, done, step_valid;
  logic [3:0] iter_cnt;
  logic s_start;
  logic [7:0] sa, sb, sc, sd;
  logic s_busy, s_done, s_sv;
  logic [3:0] s_cnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  recur_seq_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .iters(iters),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .step_valid(step_valid), .iter_cnt(iter_cnt)
  );
  recur_seq_engine #(.WIDTH(8), .ITER_W(4), .STEP_CYCLES(1)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .mode(1'b1), .iters(4'd1),
    .a_in(8'd0), .b_in(8'd127), .c_in(8'd1), .d_in(8'd0),
    .a(sa), .b(sb), .c(sc), .d(sd), .busy(s_busy), .done(s_done),
    .step_valid(s_sv), .iter_cnt(s_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic m;
    logic [3:0] n;
    logic [31:0] ai, bi, ci, di, ea, eb, ec, ed;
    int lat, steps;
  } vec_t;
  vec_t v[6];
  initial begin
    v[0] = '{0, 1, 30, 20, 15, 5, 35, 42, 16, 32, 20, 4};
    v[1] = '{0, 2, 30, 20, 15, 5, 58, 65, 17, 55, 40, 8};
    v[2] = '{1, 2, 30, 20, 15, 5, 31, 37, 17, 32, 10, 2};
    v[3] = '{1, 1, 30, 20, 15, 5, 35, 15, 16, 27, 5, 1};
    v[4] = '{0, 0, 1, 2, 3, 4, 1, 2, 3, 4, 0, 0};
    v[5] = '{0, 1, 0, 32'h7fffffff, 1, 0, 32'h80000000, 32'h80000007, 2, 32'h7ffffffd, 20, 4};
    rst = 1'b1; start = 1'b0; s_start = 1'b0; mode = 1'b0; iters = '0;
    {a_in, b_in, c_in, d_in} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset a", a, 0); chk("reset d", d, 0);
    chk("reset busy", {31'b0, busy}, 0); chk("reset done", {31'b0, done}, 0);
    chk("reset sv", {31'b0, step_valid}, 0); chk("reset iter_cnt", {28'b0, iter_cnt}, 0);
    for (int i = 0; i < 6; i++) begin
      int k, st;
      @(negedge clk);
      mode = v[i].m; iters = v[i].n;
      a_in = v[i].ai; b_in = v[i].bi; c_in = v[i].ci; d_in = v[i].di;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; st = 0;
      while (!done && k < 1000) begin
        st += step_valid;
        if (k == 2) begin
          chk($sformatf("v%0d busy", i), {31'b0, busy}, 1);
          start = 1'b1; mode = ~mode; iters = 4'd15; a_in = 32'hdead; c_in = 32'hbeef;
        end else start = 1'b0;
        @(negedge clk);
        k++;
      end
      start = 1'b0;
      st += step_valid;
      chk($sformatf("v%0d latency", i), k, v[i].lat);
      chk($sformatf("v%0d steps", i), st, v[i].steps);
      chk($sformatf("v%0d a", i), a, v[i].ea);
      chk($sformatf("v%0d b", i), b, v[i].eb);
      chk($sformatf("v%0d c", i), c, v[i].ec);
      chk($sformatf("v%0d d", i), d, v[i].ed);
      chk($sformatf("v%0d iter_cnt", i), {28'b0, iter_cnt}, {28'b0, v[i].n});
      @(negedge clk);
      chk($sformatf("v%0d idle", i), {30'b0, busy, done}, 0);
      chk($sformatf("v%0d hold a", i), a, v[i].ea);
      chk($sformatf("v%0d hold sv", i), {31'b0, step_valid}, 0);
    end
    // reset in the middle of an ordered run
    mode = 1'b0; iters = 4'd2; a_in = 30; b_in = 20; c_in = 15; d_in = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrun busy", {31'b0, busy}, 1);
    chk("midrun a", a, 35);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    chk("rst a", a, 0); chk("rst b", b, 0); chk("rst c", c, 0); chk("rst d", d, 0);
    chk("rst iter_cnt", {28'b0, iter_cnt}, 0);
    // reset wins over start on the same edge
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst prio busy", {30'b0, busy, done}, 0);
    chk("rst prio a", a, 0);
    // 8-bit wrap in parallel mode, one-cycle steps
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("w8 busy", {31'b0, s_busy}, 1);
    @(negedge clk);
    chk("w8 done", {31'b0, s_done}, 1);
    chk("w8 sv", {31'b0, s_sv}, 1);
    chk("w8 a", {24'b0, sa}, 32'h80);
    chk("w8 d", {24'b0, sd}, 32'hfd);
    chk("w8 b", {24'b0, sb}, 10);
    chk("w8 c", {24'b0, sc}, 2);
    chk("w8 iter_cnt", {28'b0, s_cnt}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/recur_seq_engine.md
RECUR_SEQ_ENGINE -- requirements
Module: recur_seq_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, 32: data width of a, b, c and d, two's complement.
REQ-003 Parameter ITER_W, 4: width of the iteration count.
REQ-004 Parameter STEP_CYCLES, 5: clock cycles per update step; legal range is 1 or more.
REQ-005 Port clk  input  1: clock, rising edge.
REQ-006 Port rst  input  1: synchronous, active-high reset.
REQ-007 Port start  input  1: request a run; sampled only in IDLE.
REQ-008 Port mode  input  1: 0 = ordered mode (chained steps), 1 = parallel mode (simultaneous update); sampled with start.
REQ-009 Port iters  input  ITER_W: number of iterations; sampled with start.
REQ-010 Ports a_in, b_in, c_in, d_in  input  WIDTH each: initial values; sampled with start.
REQ-011 Ports a, b, c, d  output  WIDTH each: current register values.
REQ-012 Port busy  output  1: high while in RUN.
REQ-013 Port done  output  1: one-cycle pulse on run completion.
REQ-014 Port step_valid  output  1: one-cycle pulse in the cycle after each register update.
REQ-015 Port iter_cnt  output  ITER_W: number of completed iterations in the current or last run.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE with start=1: at the clock edge, load a..d from a_in..d_in, latch mode and iters, clear iter_cnt, the phase counter and the wait counter.
- If iters=0: go to DONE.
- Otherwise: go to RUN.
REQ-018 In RUN, the wait counter SHALL count 0..STEP_CYCLES-1; the update happens at the edge where the count equals STEP_CYCLES-1, and the counter then returns to 0.
REQ-019 Ordered mode SHALL run four steps per iteration, in phase order 0..3. Each step sees the result of the previous step:
- phase 0: a=b+c
- phase 1: d=a-3
- phase 2: b=d+10
- phase 3: c=c+1
REQ-020 Parallel mode SHALL run one step per iteration, updating all four registers from their pre-edge values: a=b+c, d=a-3, b=d+10, c=c+1.
REQ-021 iter_cnt SHALL increment at the last step of each iteration; when the incremented value equals the latched iters, the FSM SHALL go to DONE on that same edge.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start is ignored in DONE.
REQ-023 Latency from the start edge to the done-high cycle SHALL be iters*4*STEP_CYCLES cycles in ordered mode and iters*STEP_CYCLES cycles in parallel mode; with iters=0 it is 1 cycle.
REQ-024 All arithmetic SHALL wrap modulo 2^WIDTH; there is no saturation and no overflow flag.
REQ-025 Changes on start, mode, iters or *_in while busy=1 SHALL have no effect.
REQ-026 In IDLE, a..d and iter_cnt SHALL hold the last results until the next accepted start.
REQ-027 step_valid SHALL never pulse in IDLE or DONE; done and step_valid SHALL pulse together after the final update.

Reset
REQ-028 When rst=1 at a clock edge, in any state (including mid-run), the block SHALL enter IDLE and clear a..d, iter_cnt, the phase counter and the wait counter to 0; busy, done and step_valid SHALL be 0.
REQ-029 rst SHALL take priority over start at the same edge.

Verification
REQ-030 Ordered mode, STEP_CYCLES=5, in=(30,20,15,5), iters=1:
- updates at start+5, +10, +15, +20;
- final a=35, d=32, b=42, c=16;
- done high 20 cycles after the start edge;
- 4 step_valid pulses.
REQ-031 Ordered mode, same inputs, iters=2: final a=58, d=55, b=65, c=17; iter_cnt=2; done at +40.
REQ-032 Parallel mode, same inputs, iters=2:
- after iteration 1: (a,b,c,d)=(35,15,16,27);
- after iteration 2: (31,37,17,32);
- done at +10.
REQ-033 WIDTH=8, parallel mode, in=(0,127,1,0), iters=1: a=0x80 (-128), d=0xFD, b=10, c=2 (wrap check).
REQ-034 Assert rst at cycle 7 of an ordered run: next cycle in IDLE, all outputs 0; a start pulsed while busy is ignored; iters=0 gives done one cycle after start with a..d equal to a_in..d_in.
